// File: rtl/dac_data_convert_if.sv
// Sample stream, DAC code stream and clip statistics for dac_data_convert.
// The converter sits on the slave modport and its producer/consumer on master.
interface dac_data_convert_if;
    logic [15:0] inputData;
    logic        inputValid;
    logic        inputReady;
    logic [9:0]  outputData;
    logic        outputValid;
    logic        outputReady;
    logic        clearStats;
    logic [15:0] clipCount;

    modport master (
        output inputData,
        output inputValid,
        output outputReady,
        output clearStats,
        input  inputReady,
        input  outputData,
        input  outputValid,
        input  clipCount
    );

    modport slave (
        input  inputData,
        input  inputValid,
        input  outputReady,
        input  clearStats,
        output inputReady,
        output outputData,
        output outputValid,
        output clipCount
    );
endinterface

// File: rtl/dac_data_convert.sv
// Signed 16-bit sample to unsigned 10-bit DAC code converter.
// It has one conversion stage register, an output FIFO and a saturating clip counter.
module dac_data_convert #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ROUNDING   = 1
) (
    input logic               clock,
    input logic               reset,
    dac_data_convert_if.slave bus
);
    localparam int unsigned PtrWidth = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntWidth = PtrWidth + 1;
    localparam logic signed [16:0] RoundBias = (ROUNDING != 0) ? 17'sd32 : 17'sd0;
    localparam logic [CntWidth:0] DepthLimit = (CntWidth + 1)'(FIFO_DEPTH);

    // Conversion datapath
    logic signed [16:0] extSample;
    logic signed [16:0] biasedSample;
    logic signed [16:0] shiftedSample;
    logic signed [16:0] offsetSample;
    logic [9:0]         convCode;
    logic               convClip;

    // Control and state
    logic                runState;
    logic                stageValid;
    logic [9:0]          stageData;
    logic [PtrWidth-1:0] wrPtr;
    logic [PtrWidth-1:0] rdPtr;
    logic [CntWidth-1:0] fifoCount;
    logic [CntWidth-1:0] fifoCountNext;
    logic [9:0]          fifoMem [FIFO_DEPTH];
    logic [9:0]          lastData;
    logic [15:0]         clipCount;
    logic [CntWidth:0]   occupancy;
    logic                readyInt;
    logic                outValidInt;
    logic                accept;
    logic                push;
    logic                pop;

    always_comb begin
        extSample     = {bus.inputData[15], bus.inputData};
        biasedSample  = extSample + RoundBias;
        shiftedSample = biasedSample >>> 6;
        offsetSample  = shiftedSample + 17'sd512;
        convCode      = offsetSample[9:0];
        convClip      = 1'b0;
        if (offsetSample > 17'sd1023) begin
            convCode = 10'd1023;
            convClip = 1'b1;
        end else if (offsetSample < 17'sd0) begin
            convCode = 10'd0;
            convClip = 1'b1;
        end
    end

    // Samples in the stage register are counted as occupied so that the FIFO
    // always has room for them; readiness therefore never depends on outputReady.
    always_comb begin
        occupancy   = {1'b0, fifoCount} + {{CntWidth{1'b0}}, stageValid};
        readyInt    = runState && (occupancy < DepthLimit);
        accept      = bus.inputValid && readyInt;
        push        = stageValid;
        outValidInt = (fifoCount != '0);
        pop         = outValidInt && bus.outputReady;
    end

    always_comb begin
        fifoCountNext = fifoCount;
        unique case ({push, pop})
            2'b10:   fifoCountNext = fifoCount + 1'b1;
            2'b01:   fifoCountNext = fifoCount - 1'b1;
            default: fifoCountNext = fifoCount;
        endcase
    end

    // runState keeps inputReady low during reset and raises it on the first edge after.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            runState   <= 1'b0;
            stageValid <= 1'b0;
            stageData  <= '0;
        end else begin
            runState   <= 1'b1;
            stageValid <= accept;
            if (accept) begin
                stageData <= convCode;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            lastData  <= '0;
        end else begin
            fifoCount <= fifoCountNext;
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr    <= rdPtr + 1'b1;
                lastData <= fifoMem[rdPtr];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifoMem[wrPtr] <= stageData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clipCount <= '0;
        end else if (bus.clearStats) begin
            clipCount <= '0;
        end else if (accept && convClip && (clipCount != 16'hFFFF)) begin
            clipCount <= clipCount + 16'd1;
        end
    end

    // When empty, the most recently popped code stays on outputData.
    assign bus.inputReady  = readyInt;
    assign bus.outputValid = outValidInt;
    assign bus.outputData  = outValidInt ? fifoMem[rdPtr] : lastData;
    assign bus.clipCount   = clipCount;
endmodule
